// File: rtl/rip_memory_arbiter.sv
// rip_memory_arbiter
// Shares a single rip_memory_control_unit port between instruction fetch (IF)
// and load/store (LS). Requests use a valid/ready handshake and complete with a
// one-cycle response pulse. Arbitration is round-robin with one transaction in
// flight at a time.
//
// Ports:
//   clk, rstn                    clock, synchronous active-low reset
//   if_req_valid/ready, if_addr  IF read request handshake
//   if_resp_valid, if_rdata      IF response pulse and read data
//   ls_req_valid/ready, ls_we,   LS request handshake (ls_we==0 is a read)
//   ls_addr, ls_wdata
//   ls_resp_valid, ls_rdata      LS response pulse and read data
//   mem_re/we/addr/din           memory port command
//   mem_dout, mem_busy           memory port read data and busy
//   busy                         arbiter is not idle
module rip_memory_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_resp_valid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ls_req_valid,
  output logic                  ls_req_ready,
  input  logic [3:0]            ls_we,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_resp_valid,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  mem_re,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  input  logic                  mem_busy,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, RESP} state_e;
  typedef enum logic {REQ_IF, REQ_LS} req_e;

  state_e                state_q, state_d;
  req_e                  last_grant_q, last_grant_d;
  req_e                  owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] ls_rdata_q, ls_rdata_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_LS;
      owner_q      <= REQ_IF;
      addr_q       <= '0;
      we_q         <= '0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      ls_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      if_rdata_q   <= if_rdata_d;
      ls_rdata_q   <= ls_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    if_rdata_d   = if_rdata_q;
    ls_rdata_d   = ls_rdata_q;
    if_req_ready = 1'b0;
    ls_req_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!mem_busy) begin
          // IF wins when it is alone or when LS had the previous grant.
          if (if_req_valid && (!ls_req_valid || last_grant_q == REQ_LS)) begin
            if_req_ready = 1'b1;
            owner_d      = REQ_IF;
            last_grant_d = REQ_IF;
            addr_d       = if_addr;
            we_d         = '0;
            state_d      = ISSUE;
          end else if (ls_req_valid) begin
            ls_req_ready = 1'b1;
            owner_d      = REQ_LS;
            last_grant_d = REQ_LS;
            addr_d       = ls_addr;
            we_d         = ls_we;
            wdata_d      = ls_wdata;
            state_d      = (ls_we == 4'b0) ? ISSUE : WRITE;
          end
        end
      end
      // Hold re until the memory signals it has taken the read.
      ISSUE: if (mem_busy) state_d = WAIT;
      WAIT: begin
        if (!mem_busy) begin
          if (owner_q == REQ_IF) if_rdata_d = mem_dout;
          else                   ls_rdata_d = mem_dout;
          state_d = RESP;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_re        = (state_q == ISSUE);
  assign mem_we        = (state_q == WRITE) ? we_q : '0;
  assign mem_addr      = addr_q;
  assign mem_din       = wdata_q;
  assign if_resp_valid = (state_q == RESP) && (owner_q == REQ_IF);
  assign ls_resp_valid = (state_q == RESP) && (owner_q == REQ_LS);
  assign if_rdata      = if_rdata_q;
  assign ls_rdata      = ls_rdata_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_rip_memory_arbiter.sv
// Directed testbench for rip_memory_arbiter with a small behavioural memory:
// a read is accepted when not busy, then busy is high for three cycles.
module tb_rip_memory_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic          if_req_valid, if_req_ready, if_resp_valid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          ls_req_valid, ls_req_ready, ls_resp_valid;
  logic [3:0]    ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata, ls_rdata;
  logic          mem_re, mem_busy, busy;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  always #5 clk = ~clk;

  rip_memory_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_busy(mem_busy), .busy(busy)
  );

  // Behavioural memory
  logic [31:0] mem_arr [0:255];
  int          busy_cnt = 0;
  logic        force_busy = 1'b0;
  logic [31:0] dout_q = '0;

  assign mem_busy = (busy_cnt != 0) || force_busy;
  assign mem_dout = dout_q;

  always @(posedge clk) begin
    logic [31:0] w;
    if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    else if (mem_re) begin
      busy_cnt <= 3;
      dout_q   <= mem_arr[mem_addr[9:2]];
    end
    if (mem_we != 4'b0) begin
      w = mem_arr[mem_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) w[8*b +: 8] = mem_din[8*b +: 8];
      mem_arr[mem_addr[9:2]] <= w;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Protocol monitor: every response needs an accepted request, never with ready.
  bit if_out = 0, ls_out = 0;
  int overlap = 0;
  always @(posedge clk) begin
    if (!rstn) begin
      if_out = 0;
      ls_out = 0;
    end else begin
      if (if_resp_valid) begin
        check("if_resp_after_req", {31'b0, if_out}, 1);
        check("if_resp_vs_ready", {31'b0, if_req_ready}, 0);
        if_out = 0;
      end
      if (ls_resp_valid) begin
        check("ls_resp_after_req", {31'b0, ls_out}, 1);
        check("ls_resp_vs_ready", {31'b0, ls_req_ready}, 0);
        ls_out = 0;
      end
      if (if_req_valid && if_req_ready) if_out = 1;
      if (ls_req_valid && ls_req_ready) ls_out = 1;
      if (mem_re && mem_we != 4'b0) overlap++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call one cycle after the handshake; returns cycles since accept, -1 on timeout.
  task automatic wait_resp(input bit want_if, output int lat);
    lat = 1;
    while (!(want_if ? if_resp_valid : ls_resp_valid) && lat < 30) begin
      tick();
      lat++;
    end
    if (!(want_if ? if_resp_valid : ls_resp_valid)) lat = -1;
  endtask

  // Grant log: gwho 0=IF 1=LS, gcyc = cycle index of the grant.
  int gwho [8];
  int gcyc [8];
  int ng;

  // mode 0: both requests held. mode 1: LS swaps to a second write after its
  // first grant and drops after the second; IF drops after its grant.
  task automatic run_grants(input int ncyc, input int mode);
    bit g_if, g_ls;
    int nls;
    ng  = 0;
    nls = 0;
    for (int c = 0; c < ncyc; c++) begin
      #1;
      g_if = if_req_ready;
      g_ls = ls_req_ready;
      if (g_if && g_ls) check("both_ready", 1, 0);
      if (g_if && ng < 8) begin gwho[ng] = 0; gcyc[ng] = c; ng++; end
      if (g_ls && ng < 8) begin gwho[ng] = 1; gcyc[ng] = c; ng++; end
      tick();
      if (mode == 1) begin
        if (g_ls) begin
          nls++;
          if (nls == 1) begin
            ls_we    = 4'b1100;
            ls_addr  = 32'h34;
            ls_wdata = 32'h5A5A1234;
          end else ls_req_valid = 1'b0;
        end
        if (g_if) if_req_valid = 1'b0;
      end
    end
  endtask

  initial begin
    int lat;
    int pulses;
    for (int i = 0; i < 256; i++) mem_arr[i] = '0;
    mem_arr[32'h10 >> 2] = 32'hDEADBEEF;
    mem_arr[32'h20 >> 2] = 32'hFFFFFFFF;
    rstn = 1'b0;
    if_req_valid = 1'b0; if_addr = '0;
    ls_req_valid = 1'b0; ls_we = '0; ls_addr = '0; ls_wdata = '0;
    tick(); tick();
    rstn = 1'b1;

    // Reset state
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_mem_re", {31'b0, mem_re}, 0);
    check("rst_mem_we", {28'b0, mem_we}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_ls_rdata", ls_rdata, 0);
    check("rst_resp", {30'b0, if_resp_valid, ls_resp_valid}, 0);

    // 1. IF-only read
    if_req_valid = 1'b1; if_addr = 32'h10;
    #1;
    check("t1_if_ready", {31'b0, if_req_ready}, 1);
    check("t1_ls_ready", {31'b0, ls_req_ready}, 0);
    tick();
    if_req_valid = 1'b0; if_addr = 32'hBAD0;
    check("t1_mem_re", {31'b0, mem_re}, 1);
    check("t1_mem_addr", mem_addr, 32'h10);
    check("t1_busy", {31'b0, busy}, 1);
    check("t1_if_ready_busy", {31'b0, if_req_ready}, 0);
    wait_resp(1, lat);
    check("t1_latency", lat, 6);
    check("t1_if_rdata", if_rdata, 32'hDEADBEEF);
    tick();
    check("t1_resp_pulse", {31'b0, if_resp_valid}, 0);
    check("t1_idle", {31'b0, busy}, 0);
    check("t1_rdata_hold", if_rdata, 32'hDEADBEEF);

    // 2. LS write then read back
    ls_req_valid = 1'b1; ls_we = 4'b0011; ls_addr = 32'h20; ls_wdata = 32'h1234ABCD;
    #1;
    check("t2_ls_ready", {31'b0, ls_req_ready}, 1);
    tick();
    ls_req_valid = 1'b0; ls_we = '0; ls_addr = '0; ls_wdata = '0;
    check("t2_mem_we", {28'b0, mem_we}, 4'b0011);
    check("t2_mem_re", {31'b0, mem_re}, 0);
    check("t2_mem_addr", mem_addr, 32'h20);
    check("t2_mem_din", mem_din, 32'h1234ABCD);
    wait_resp(0, lat);
    check("t2_wr_latency", lat, 2);
    check("t2_mem_we_off", {28'b0, mem_we}, 0);
    check("t2_ls_rdata_keep", ls_rdata, 0);
    tick();
    ls_req_valid = 1'b1; ls_we = 4'b0000; ls_addr = 32'h20;
    #1;
    check("t2_rd_ready", {31'b0, ls_req_ready}, 1);
    tick();
    ls_req_valid = 1'b0; ls_addr = '0;
    wait_resp(0, lat);
    check("t2_rd_latency", lat, 6);
    check("t2_ls_rdata", ls_rdata, 32'hFFFFABCD);
    tick();

    // 3. Simultaneous requests after reset alternate IF, LS, IF, LS
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    if_req_valid = 1'b1; if_addr = 32'h10;
    ls_req_valid = 1'b1; ls_we = 4'b0; ls_addr = 32'h20;
    run_grants(25, 0);
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("t3_ngrants", ng, 4);
    check("t3_g0_who", gwho[0], 0);
    check("t3_g1_who", gwho[1], 1);
    check("t3_g2_who", gwho[2], 0);
    check("t3_g3_who", gwho[3], 1);
    check("t3_g1_cyc", gcyc[1], 7);
    check("t3_g2_cyc", gcyc[2], 14);
    check("t3_g3_cyc", gcyc[3], 21);
    check("t3_if_rdata", if_rdata, 32'hDEADBEEF);
    check("t3_ls_rdata", ls_rdata, 32'hFFFFABCD);

    // 4. Reset during WAIT drops the transaction
    if_req_valid = 1'b1; if_addr = 32'h20;
    #1;
    check("t4_if_ready", {31'b0, if_req_ready}, 1);
    tick();
    if_req_valid = 1'b0;
    tick(); tick();
    check("t4_in_wait_busy", {31'b0, busy}, 1);
    check("t4_in_wait_re", {31'b0, mem_re}, 0);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("t4_busy", {31'b0, busy}, 0);
    check("t4_mem_re", {31'b0, mem_re}, 0);
    check("t4_mem_we", {28'b0, mem_we}, 0);
    check("t4_mem_addr", mem_addr, 0);
    check("t4_if_rdata", if_rdata, 0);
    check("t4_ls_rdata", ls_rdata, 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (if_resp_valid || ls_resp_valid) pulses++;
      tick();
    end
    check("t4_no_resp", pulses, 0);

    // 5. mem_busy blocks the grant; release grants in the same cycle
    force_busy = 1'b1;
    if_req_valid = 1'b1; if_addr = 32'h10;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t5_blocked", {31'b0, if_req_ready}, 0);
      tick();
    end
    force_busy = 1'b0;
    #1;
    check("t5_released", {31'b0, if_req_ready}, 1);
    tick();
    if_req_valid = 1'b0;
    wait_resp(1, lat);
    check("t5_latency", lat, 6);
    check("t5_if_rdata", if_rdata, 32'hDEADBEEF);
    tick();

    // 6. Back-to-back LS writes with IF pending
    if_req_valid = 1'b1; if_addr = 32'h10;
    ls_req_valid = 1'b1; ls_we = 4'b1111; ls_addr = 32'h30; ls_wdata = 32'hA5A5A5A5;
    run_grants(20, 1);
    for (int i = 0; i < 4; i++) tick();
    check("t6_ngrants", ng, 3);
    check("t6_g0_who", gwho[0], 1);
    check("t6_g1_who", gwho[1], 0);
    check("t6_g2_who", gwho[2], 1);
    check("t6_g1_cyc", gcyc[1], 3);
    check("t6_g2_cyc", gcyc[2], 10);
    check("t6_word30", mem_arr[32'h30 >> 2], 32'hA5A5A5A5);
    check("t6_word34", mem_arr[32'h34 >> 2], 32'h5A5A0000);
    check("re_we_overlap", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
